// File: rtl/axi4_lite_line_fill_if.sv
// Bundle between the line-fill sequencer, the cache that requests lines and the
// single-word AXI4-Lite read master. The sequencer takes the master modport.
interface axi4_lite_line_fill_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WORDS    = 16
);
  // req_* and line_* transfer on a cycle where valid & ready are both high;
  // valid may not depend on ready, and payload is held stable while valid waits.
  logic                                  req_valid_i;
  logic                                  req_ready_o;
  logic [AXI_ADDR_WIDTH-1:0]             req_addr_i;
  logic                                  line_valid_o;
  logic                                  line_ready_i;
  logic [BLOCK_WORDS*AXI_DATA_WIDTH-1:0] line_data_o;
  logic                                  line_fault_o;
  logic                                  rd_start_o;
  logic [AXI_ADDR_WIDTH-1:0]             rd_addr_o;
  logic [AXI_DATA_WIDTH-1:0]             rd_data_i;
  logic                                  rd_fault_i;
  logic                                  rd_done_i;
  logic [1:0]                            fill_state;

  modport master (
    input  req_valid_i, req_addr_i, line_ready_i, rd_data_i, rd_fault_i, rd_done_i,
    output req_ready_o, line_valid_o, line_data_o, line_fault_o, rd_start_o,
           rd_addr_o, fill_state
  );

  modport slave (
    output req_valid_i, req_addr_i, line_ready_i, rd_data_i, rd_fault_i, rd_done_i,
    input  req_ready_o, line_valid_o, line_data_o, line_fault_o, rd_start_o,
           rd_addr_o, fill_state
  );
endinterface

// File: rtl/axi4_lite_line_fill.sv
// Cache-line fill sequencer: turns one line request into BLOCK_WORDS sequential
// single-word reads, packs the returned words and presents the line with a fault flag.
module axi4_lite_line_fill #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WORDS    = 16
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  axi4_lite_line_fill_if.master bus
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = $clog2(BLOCK_WORDS);
  localparam int OFFW  = CW + BSH;
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(AXI_ADDR_WIDTH-OFFW){1'b1}}, {OFFW{1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                                state, state_nxt;
  logic [CW-1:0]                         cnt;
  logic [AXI_ADDR_WIDTH-1:0]             base;
  logic [BLOCK_WORDS*AXI_DATA_WIDTH-1:0] line_data;
  logic                                  line_fault;
  logic                                  req_ready, rd_start, line_valid;
  logic                                  accept, word_ack;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rd_start   = 1'b0;
    line_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        rd_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rd_done_i) begin
          if (bus.rd_fault_i || cnt == LAST) state_nxt = S_DONE;
          else                               state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        line_valid = 1'b1;
        if (bus.line_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept   = (state == S_IDLE) && bus.req_valid_i;
  // Read completions are only meaningful while a read is outstanding.
  assign word_ack = (state == S_WAIT) && bus.rd_done_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt        <= '0;
      base       <= '0;
      line_data  <= '0;
      line_fault <= 1'b0;
    end else begin
      if (accept) begin
        base       <= bus.req_addr_i & ALIGN_MASK;
        cnt        <= '0;
        line_fault <= 1'b0;
      end
      if (word_ack) begin
        line_data[int'(cnt)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= bus.rd_data_i;
        if (bus.rd_fault_i)  line_fault <= 1'b1;
        else if (cnt != LAST) cnt       <= cnt + 1'b1;
      end
    end
  end

  // Base is line-aligned, so OR-ing in the word offset never carries.
  assign bus.rd_addr_o    = base | (AXI_ADDR_WIDTH'(cnt) << BSH);
  assign bus.rd_start_o   = rd_start;
  assign bus.req_ready_o  = req_ready;
  assign bus.line_valid_o = line_valid;
  assign bus.line_data_o  = line_data;
  assign bus.line_fault_o = line_fault;
  assign bus.fill_state   = state;
endmodule
